// File: rtl/video_out_timing_pkg.sv
// Shared types and constants for the HDMI output timing block: controller states,
// fixed pixel words and the UYVY colour-bar table.
package video_out_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    localparam int          cCntW  = 12;
    localparam logic [15:0] cBlack = 16'h1080;
    localparam logic [15:0] cBlank = 16'h0000;

    // Bars in {Y, U, V}: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] cBarTable [8] = '{
        24'hEB8080, 24'hD21092, 24'hAAA610, 24'h913622,
        24'h6ACADE, 24'h515AF0, 24'h29F06E, 24'h108080
    };

    // Words carry {Y, chroma}; chroma alternates U on even pixels and V on odd pixels.
    function automatic logic [15:0] barWord(input logic [2:0] barIdx, input logic oddPix);
        logic [23:0] yuv;
        yuv = cBarTable[barIdx];
        return oddPix ? {yuv[23:16], yuv[7:0]} : {yuv[23:16], yuv[15:8]};
    endfunction

endpackage

// File: rtl/video_out_fifo.sv
// Single-clock show-ahead FIFO: block-RAM storage with a registered read that
// prefetches into a head register, plus an exact fill-level count.
module video_out_fifo #(
    parameter int pDepth = 2048,
    parameter int pWidth = 16
) (
    input  logic                      iCLK,
    input  logic                      inRST,
    input  logic                      iWrEn,
    input  logic [pWidth-1:0]         iWrData,
    input  logic                      iRdEn,
    output logic [pWidth-1:0]         oHead,
    output logic                      oHeadValid,
    output logic [$clog2(pDepth):0]   oLevel
);
    localparam int cAw   = $clog2(pDepth);
    localparam int cLvlW = cAw + 1;
    localparam logic [cAw-1:0]   cPtrOne = cAw'(1);
    localparam logic [cLvlW-1:0] cLvlOne = cLvlW'(1);
    localparam logic [cLvlW-1:0] cFull   = cLvlW'(pDepth);

    logic [pWidth-1:0] mem [pDepth];
    logic [pWidth-1:0] headReg;
    logic [cAw-1:0]    wrPtrReg, rdPtrReg;
    logic [cLvlW-1:0]  ramCntReg, levelReg;
    logic              headValidReg;
    logic              wrAcc, popAcc, ramRd;

    assign wrAcc  = iWrEn && (levelReg != cFull);
    assign popAcc = iRdEn && headValidReg;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign ramRd  = (ramCntReg != '0) && (!headValidReg || popAcc);

    always_ff @(posedge iCLK) begin
        if (wrAcc) begin
            mem[wrPtrReg] <= iWrData;
        end
        if (ramRd) begin
            headReg <= mem[rdPtrReg];
        end
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            wrPtrReg     <= '0;
            rdPtrReg     <= '0;
            ramCntReg    <= '0;
            levelReg     <= '0;
            headValidReg <= 1'b0;
        end else begin
            if (wrAcc) begin
                wrPtrReg <= wrPtrReg + cPtrOne;
            end
            if (ramRd) begin
                rdPtrReg <= rdPtrReg + cPtrOne;
            end
            unique case ({wrAcc, ramRd})
                2'b10:   ramCntReg <= ramCntReg + cLvlOne;
                2'b01:   ramCntReg <= ramCntReg - cLvlOne;
                default: ramCntReg <= ramCntReg;
            endcase
            unique case ({wrAcc, popAcc})
                2'b10:   levelReg <= levelReg + cLvlOne;
                2'b01:   levelReg <= levelReg - cLvlOne;
                default: levelReg <= levelReg;
            endcase
            if (ramRd) begin
                headValidReg <= 1'b1;
            end else if (popAcc) begin
                headValidReg <= 1'b0;
            end
        end
    end

    assign oHead      = headReg;
    assign oHeadValid = headValidReg;
    assign oLevel     = levelReg;

endmodule

// File: rtl/video_out_timing.sv
// Buffers upstream UYVY words and replays them under HDMI raster timing.
// Defining VIDEO_OUT_TEST_PATTERN_EN adds iPatternSel and a colour-bar generator.
module video_out_timing
    import video_out_timing_pkg::*;
#(
    parameter int pHActive    = 1280,
    parameter int pHFront     = 110,
    parameter int pHSync      = 40,
    parameter int pHBack      = 220,
    parameter int pVActive    = 720,
    parameter int pVFront     = 5,
    parameter int pVSync      = 5,
    parameter int pVBack      = 20,
    parameter int pFifoDepth  = 2048,
    parameter int pStartLevel = 1024
) (
    input  logic        iCLK,
    input  logic        inRST,
    input  logic [15:0] iVideoData,
    input  logic        iVideoVd,
    output logic        oVideofull,
`ifdef VIDEO_OUT_TEST_PATTERN_EN
    input  logic        iPatternSel,
`endif
    output logic [15:0] oHdmiData,
    output logic        oHdmiDe,
    output logic        oHdmiHs,
    output logic        oHdmiVs,
    output logic        oFrameStart,
    output logic        oUnderflow,
    input  logic        iClrUnderflow
);
    // Htotal and Vtotal must not exceed 4096 so the 12-bit counters cover them.
    localparam int cHTotal = pHActive + pHFront + pHSync + pHBack;
    localparam int cVTotal = pVActive + pVFront + pVSync + pVBack;
    localparam int cLvlW   = $clog2(pFifoDepth) + 1;

    localparam logic [cCntW-1:0] cCntOne     = cCntW'(1);
    localparam logic [cCntW-1:0] cHLast      = cCntW'(cHTotal - 1);
    localparam logic [cCntW-1:0] cVLast      = cCntW'(cVTotal - 1);
    localparam logic [cCntW-1:0] cHActLast   = cCntW'(pHActive - 1);
    localparam logic [cCntW-1:0] cVActLast   = cCntW'(pVActive - 1);
    localparam logic [cCntW-1:0] cHSyncFirst = cCntW'(pHActive + pHFront);
    localparam logic [cCntW-1:0] cHSyncLast  = cCntW'(pHActive + pHFront + pHSync - 1);
    localparam logic [cCntW-1:0] cVSyncFirst = cCntW'(pVActive + pVFront);
    localparam logic [cCntW-1:0] cVSyncLast  = cCntW'(pVActive + pVFront + pVSync - 1);
    localparam logic [cLvlW-1:0] cStartLvl   = cLvlW'(pStartLevel);
    localparam logic [cLvlW-1:0] cAlmostFull = cLvlW'(pFifoDepth - 16);

    state_t             stateReg;
    logic [cCntW-1:0]   hCntReg, vCntReg;
    logic [15:0]        dataReg;
    logic               deReg, hsReg, vsReg, fsReg, uflReg;
    logic [cLvlW-1:0]   fifoLevel;
    logic [15:0]        fifoHead;
    logic               fifoHeadValid;
    logic               inActive, inHSync, inVSync, rdEn, uflSet;
    logic [15:0]        pixWord;

    assign inActive = (hCntReg <= cHActLast) && (vCntReg <= cVActLast);
    assign inHSync  = (hCntReg >= cHSyncFirst) && (hCntReg <= cHSyncLast);
    assign inVSync  = (vCntReg >= cVSyncFirst) && (vCntReg <= cVSyncLast);
    assign rdEn     = (stateReg == ST_RUN) && inActive;

    video_out_fifo #(
        .pDepth (pFifoDepth),
        .pWidth (16)
    ) uFifo (
        .iCLK       (iCLK),
        .inRST      (inRST),
        .iWrEn      (iVideoVd),
        .iWrData    (iVideoData),
        .iRdEn      (rdEn),
        .oHead      (fifoHead),
        .oHeadValid (fifoHeadValid),
        .oLevel     (fifoLevel)
    );

`ifdef VIDEO_OUT_TEST_PATTERN_EN
    localparam logic [cCntW-1:0] cBarLast = cCntW'(pHActive / 8 - 1);

    logic [cCntW-1:0] barCntReg;
    logic [2:0]       barIdxReg;

    // Bar position tracks hcnt so no divider is needed.
    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            barCntReg <= '0;
            barIdxReg <= '0;
        end else if (stateReg == ST_RUN) begin
            if (hCntReg == cHLast) begin
                barCntReg <= '0;
                barIdxReg <= '0;
            end else if (barCntReg == cBarLast) begin
                barCntReg <= '0;
                barIdxReg <= barIdxReg + 3'd1;
            end else begin
                barCntReg <= barCntReg + cCntOne;
            end
        end
    end
`endif

    always_comb begin
        pixWord = fifoHeadValid ? fifoHead : cBlack;
        uflSet  = rdEn && !fifoHeadValid;
`ifdef VIDEO_OUT_TEST_PATTERN_EN
        if (iPatternSel) begin
            pixWord = barWord(barIdxReg, hCntReg[0]);
            uflSet  = 1'b0;
        end
`endif
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            stateReg <= ST_IDLE;
            hCntReg  <= '0;
            vCntReg  <= '0;
            dataReg  <= cBlank;
            deReg    <= 1'b0;
            hsReg    <= 1'b0;
            vsReg    <= 1'b0;
            fsReg    <= 1'b0;
            uflReg   <= 1'b0;
        end else begin
            unique case (stateReg)
                ST_IDLE: stateReg <= ST_FILL;
                ST_FILL: begin
                    if (fifoLevel >= cStartLvl) begin
                        stateReg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Outputs are the registered image of this cycle's counters.
                    deReg   <= inActive;
                    hsReg   <= inHSync;
                    vsReg   <= inVSync;
                    fsReg   <= inActive && (hCntReg == '0) && (vCntReg == '0);
                    dataReg <= inActive ? pixWord : cBlank;
                    if (hCntReg == cHLast) begin
                        hCntReg <= '0;
                        vCntReg <= (vCntReg == cVLast) ? '0 : vCntReg + cCntOne;
                    end else begin
                        hCntReg <= hCntReg + cCntOne;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
            if (uflSet) begin
                uflReg <= 1'b1;
            end else if (iClrUnderflow) begin
                uflReg <= 1'b0;
            end
        end
    end

    assign oVideofull  = fifoLevel >= cAlmostFull;
    assign oHdmiData   = dataReg;
    assign oHdmiDe     = deReg;
    assign oHdmiHs     = hsReg;
    assign oHdmiVs     = vsReg;
    assign oFrameStart = fsReg;
    assign oUnderflow  = uflReg;

endmodule

// File: tb/tb_video_out_timing.sv
// Bench for video_out_timing on a shrunken raster: a queue-based reference model
// checks every output each clock, plus a timing vector table and corner-case sequences.
`timescale 1ns/1ps
module tb_video_out_timing;
    localparam int HA = 32, HF = 4, HS = 3, HB = 5;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int DEPTH = 64, START = 32;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [15:0] BLACK = 16'h1080;

    logic        iCLK = 1'b0;
    logic        inRST = 1'b0;
    logic [15:0] iVideoData = '0;
    logic        iVideoVd = 1'b0;
    logic        iClrUnderflow = 1'b0;
    logic        patSel = 1'b0;
    logic        oVideofull;
    logic [15:0] oHdmiData;
    logic        oHdmiDe, oHdmiHs, oHdmiVs, oFrameStart, oUnderflow;

    always #5 iCLK = ~iCLK;

    video_out_timing #(
        .pHActive(HA), .pHFront(HF), .pHSync(HS), .pHBack(HB),
        .pVActive(VA), .pVFront(VF), .pVSync(VS), .pVBack(VB),
        .pFifoDepth(DEPTH), .pStartLevel(START)
    ) dut (
        .iCLK          (iCLK),
        .inRST         (inRST),
        .iVideoData    (iVideoData),
        .iVideoVd      (iVideoVd),
        .oVideofull    (oVideofull),
`ifdef VIDEO_OUT_TEST_PATTERN_EN
        .iPatternSel   (patSel),
`endif
        .oHdmiData     (oHdmiData),
        .oHdmiDe       (oHdmiDe),
        .oHdmiHs       (oHdmiHs),
        .oHdmiVs       (oHdmiVs),
        .oFrameStart   (oFrameStart),
        .oUnderflow    (oUnderflow),
        .iClrUnderflow (iClrUnderflow)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: accepted words in order, raster index since timing start.
    logic [15:0] q[$];
    bit          mRun = 0;
    int          mIdx = 0;
    bit          mUfl = 0;
    bit          capEn = 1;
    logic [3:0]  cap [600];
    logic [23:0] bars [8] = '{24'hEB8080, 24'hD21092, 24'hAAA610, 24'h913622,
                              24'h6ACADE, 24'h515AF0, 24'h29F06E, 24'h108080};

    typedef struct {
        int         k;
        logic [3:0] exp;   // {de, hs, vs, fs}
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] barPix(input int h);
        logic [23:0] yuv;
        yuv = bars[h / (HA / 8)];
        return (h % 2 == 1) ? {yuv[23:16], yuv[7:0]} : {yuv[23:16], yuv[15:8]};
    endfunction

    function automatic bit nextActive();
        int n;
        n = mIdx + 1;
        return mRun && (n >= 0) && ((n % HT) < HA) && (((n / HT) % VT) < VA);
    endfunction

    task automatic tick(input logic vd, input logic [15:0] d, input logic clr);
        bit          acc, setU;
        logic        de, hs, vs, fs;
        logic [15:0] od, tmp;
        int          h, v;
        de = 0; hs = 0; vs = 0; fs = 0; od = '0; setU = 0;
        iVideoVd = vd; iVideoData = d; iClrUnderflow = clr;
        @(posedge iCLK);
        #1;
        acc = vd && (q.size() < DEPTH);
        if (mRun) begin
            mIdx++;
            if (mIdx >= 0) begin
                h  = mIdx % HT;
                v  = (mIdx / HT) % VT;
                de = (h < HA) && (v < VA);
                hs = (h >= HA + HF) && (h < HA + HF + HS);
                vs = (v >= VA + VF) && (v < VA + VF + VS);
                fs = de && (h == 0) && (v == 0);
                if (de) begin
                    od = patSel ? barPix(h) : BLACK;
                    if (q.size() > 0) begin
                        tmp = q.pop_front();
                        if (!patSel) od = tmp;
                    end else if (!patSel) begin
                        setU = 1;
                    end
                end
            end
        end
        if (acc) q.push_back(d);
        if (setU) mUfl = 1;
        else if (clr) mUfl = 0;
        if (!mRun && q.size() >= START) begin
            mRun = 1;
            mIdx = -2;
        end
        check("outputs{de,hs,vs,fs,ufl,full,data}",
              {oHdmiDe, oHdmiHs, oHdmiVs, oFrameStart, oUnderflow, oVideofull, oHdmiData},
              {de, hs, vs, fs, mUfl, (q.size() >= DEPTH - 16), od});
        if (capEn && mIdx >= 0 && mIdx < 600)
            cap[mIdx] = {oHdmiDe, oHdmiHs, oHdmiVs, oFrameStart};
    endtask

    task automatic randTicks(input int n);
        for (int i = 0; i < n; i++)
            tick($urandom_range(7) != 0, 16'($urandom), $urandom_range(63) == 0);
    endtask

    initial begin
        vec_t tab[15];
        int   deCnt, blackCnt;
        bit   reached, didSet, didClr, c1, c2;

        tab = '{'{0, 4'b1001}, '{31, 4'b1000}, '{32, 4'b0000}, '{35, 4'b0000},
                '{36, 4'b0100}, '{38, 4'b0100}, '{39, 4'b0000}, '{44, 4'b1000},
                '{263, 4'b0000}, '{264, 4'b0000}, '{308, 4'b0010}, '{392, 4'b0010},
                '{396, 4'b0000}, '{440, 4'b1001}, '{477, 4'b0100}};

        // Reset state.
        #2;
        check("reset_outputs",
              {oHdmiDe, oHdmiHs, oHdmiVs, oFrameStart, oUnderflow, oVideofull, oHdmiData}, '0);
        @(negedge iCLK);
        @(negedge iCLK);
        inRST = 1'b1;
        $display("seq reset: outputs idle after power-on reset");

        // Fill to the start level, then expect De exactly two clocks after the last write.
        for (int i = 0; i < START; i++) tick(1'b1, 16'($urandom), 1'b0);
        tick(1'b0, '0, 1'b0);
        check("start_latency_de_early", oHdmiDe, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("start_latency_de_fs", {oHdmiDe, oFrameStart}, 2'b11);
        $display("seq start: first De/FrameStart two clocks after level reached");

        // Random supply over three frames; runs into full and dropped words.
        randTicks(3 * HT * VT);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("timing_k%0d", tab[i].k), cap[tab[i].k], tab[i].exp);
            $display("vec k=%0d {de,hs,vs,fs} got %b", tab[i].k, cap[tab[i].k]);
        end

        // Reset in the middle of line 3.
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            tick($urandom_range(7) != 0, 16'($urandom), 1'b0);
            reached = (mIdx >= 0) && (((mIdx / HT) % VT) == 3) && ((mIdx % HT) == 10);
        end
        check("reach_line3", reached, 1'b1);
        inRST = 1'b0;
        #2;
        check("midframe_reset_outputs",
              {oHdmiDe, oHdmiHs, oHdmiVs, oFrameStart, oUnderflow, oVideofull, oHdmiData}, '0);
        q.delete();
        mRun = 0; mUfl = 0; capEn = 0;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        inRST = 1'b1;
        deCnt = 0;
        for (int i = 0; i < START - 1; i++) begin
            tick(1'b1, 16'($urandom), 1'b0);
            deCnt += int'(oHdmiDe);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, '0, 1'b0);
            deCnt += int'(oHdmiDe);
        end
        check("no_de_before_refill", deCnt, 0);
        tick(1'b1, 16'($urandom), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("restart_de_fs", {oHdmiDe, oFrameStart}, 2'b11);
        $display("seq midframe reset: outputs cleared, restart after refill");
        randTicks(HT * VT + 60);

`ifdef VIDEO_OUT_TEST_PATTERN_EN
        patSel = 1'b1;
        randTicks(HT * VT);
        patSel = 1'b0;
        $display("seq pattern: one frame of colour bars");
`endif

        // Starve the buffer: black pixels, set-wins on a clear pulse, clear in blanking.
        blackCnt = 0; didSet = 0; didClr = 0;
        for (int i = 0; i < 12 * HT; i++) begin
            c1 = !didSet && nextActive() && (q.size() == 0);
            c2 = didSet && !didClr && !nextActive() && mUfl;
            tick(1'b0, '0, c1 || c2);
            if (oHdmiDe && oHdmiData == BLACK) blackCnt++;
            if (c1) begin
                check("ufl_set_wins", oUnderflow, 1'b1);
                didSet = 1;
            end
            if (c2) begin
                check("ufl_cleared", oUnderflow, 1'b0);
                didClr = 1;
            end
        end
        check("black_pixels_seen", blackCnt > 0, 1'b1);
        check("ufl_sequence_done", {didSet, didClr}, 2'b11);
        check("ufl_sticky_end", oUnderflow, 1'b1);
        $display("seq underflow: %0d black De pixels", blackCnt);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/video_out_timing.md
VIDEO_OUT_TIMING -- requirements
Module: video_out_timing

Interface
REQ-001 Parameter pHActive, default 1280, sets active pixels per line.
REQ-002 Parameter pHFront, default 110; pHSync, default 40; pHBack, default 220: horizontal blanking in clocks.
REQ-003 Parameter pVActive, default 720, sets active lines per frame.
REQ-004 Parameter pVFront, default 5; pVSync, default 5; pVBack, default 20: vertical blanking in lines.
REQ-005 Parameter pFifoDepth, default 2048, is the input buffer depth in 16-bit words (power of two).
REQ-006 Parameter pStartLevel, default 1024, is the fill level required before timing starts.
REQ-007 Port iCLK, input, 1, is the pixel clock; it is the only clock.
REQ-008 Port inRST, input, 1, is the asynchronous, active-low reset.
REQ-009 Port iVideoData, input, 16, carries the UYVY word from the upstream CSI receive stage.
REQ-010 Port iVideoVd, input, 1, qualifies iVideoData.
REQ-011 Port oVideofull, output, 1, is backpressure to the upstream stage.
REQ-012 Port oHdmiData, output, 16, carries the UYVY pixel word.
REQ-013 Ports oHdmiDe, oHdmiHs and oHdmiVs, output, 1 each, are data enable, hsync and vsync (active-high).
REQ-014 Port oFrameStart, output, 1, is a one-clock pulse on the first active pixel of each frame.
REQ-015 Port oUnderflow, output, 1, is a sticky flag for starvation during active video.
REQ-016 Port iClrUnderflow, input, 1, clears oUnderflow.

Function
REQ-017 Input write: a word SHALL be written when iVideoVd=1 and the buffer is not full; a word offered while full SHALL be dropped.
REQ-018 oVideofull SHALL assert when the fill level is at or above pFifoDepth-16.
REQ-019 State machine: IDLE -> FILL on exit from reset; FILL -> RUN when level>=pStartLevel, with hcnt=vcnt=0 on the RUN entry cycle; RUN stays in RUN.
REQ-020 In IDLE/FILL, outputs SHALL hold their reset values and no read SHALL occur.
REQ-021 hcnt SHALL count 0..Htotal-1, where Htotal=pHActive+pHFront+pHSync+pHBack, and wrap to 0; vcnt SHALL increment on hcnt wrap over 0..Vtotal-1, then wrap.
REQ-022 Active region is hcnt<pHActive and vcnt<pVActive.
REQ-023 Hsync SHALL be active for pHActive+pHFront <= hcnt < pHActive+pHFront+pHSync; vsync by the same rule on vcnt.
REQ-024 In the active region, one word SHALL be popped per clock; all outputs SHALL be registered with latency exactly 1 clock from counter state, so De, Hs, Vs and data stay aligned.
REQ-025 If the buffer is empty in the active region, oHdmiData SHALL be 16'h1080 (black), oHdmiDe SHALL still assert, and oUnderflow SHALL set.
REQ-026 Outside the active region, oHdmiData SHALL be 16'h0000.
REQ-027 oFrameStart SHALL pulse aligned with oHdmiDe at hcnt=0, vcnt=0.
REQ-028 On simultaneous set and iClrUnderflow, set SHALL win.
REQ-029 On simultaneous write and read, the level SHALL be unchanged; pointers SHALL wrap modulo pFifoDepth.
REQ-030 Counters SHALL be 12 bits; Htotal<=4096 and Vtotal<=4096 are required parameter limits.

Reset
REQ-031 On inRST=0, asynchronously: state=IDLE, counters=0, buffer empty, and oHdmiData=0, oHdmiDe=0, oHdmiHs=0, oHdmiVs=0, oFrameStart=0, oUnderflow=0, oVideofull=0.
REQ-032 A reset asserted mid-frame SHALL discard buffer contents; after release, the block SHALL refill to pStartLevel before restarting timing.

Configuration
REQ-033 Macro VIDEO_OUT_TEST_PATTERN_EN, when defined, adds input iPatternSel (1 bit).
REQ-034 With the macro defined and iPatternSel=1, active pixels SHALL be 8 UYVY colour bars of pHActive/8 pixels each; the buffer SHALL still be drained and no underflow SHALL be flagged.
REQ-035 Without the macro, the port and the pattern logic SHALL be absent.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE, FILL, RUN), the black word 16'h1080 and the colour-bar table constants.
REQ-037 The buffer SHALL be one sub-module, video_out_fifo: a single-clock FIFO with level output and BRAM inference.

Verification
REQ-038 Reset release, 1024 words written -> RUN entered on the next clock; first oHdmiDe one clock later with oFrameStart=1.
REQ-039 Continuous supply -> exactly 1280 De clocks per line, 720 De lines, hsync width 40 clocks, vsync width 5 lines, Htotal 1650.
REQ-040 Supply stopped mid-line -> oHdmiData=16'h1080 while De is asserted; oUnderflow=1 until iClrUnderflow pulses.
REQ-041 Level 2032 reached -> oVideofull=1; an extra word written while full is dropped, and the count is unchanged.
REQ-042 inRST pulsed at line 300 -> all outputs 0 immediately; no De until 1024 new words are buffered.
REQ-043 Macro defined with iPatternSel=1 -> the first 160 pixels equal bar-0 words and the buffer still drains.
